// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver FSM state type.
package uart_pkg;

  localparam int DEFAULT_DELAY_FRAMES = 234;
  localparam int FRAME_BITS           = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rxState_t;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead FIFO: head visible combinationally, new head the cycle after a pop.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop   = pop && !empty;
  // When full, a concurrent pop frees the very slot the push lands in.
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr[AW-1:0]] <= pushData;
        wrPtr              <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte pushed ~9.5 bit times after the start edge.
// Bytes leave through a valid/ready FIFO; the FSM never stalls, full FIFO drops and flags overflow.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  uartRx,
  output logic [FRAME_BITS-1:0] rxData,
  output logic                  rxValid,
  input  logic                  rxReady,
  output logic                  frameError,
  output logic                  overflow,
  input  logic                  errClear
);

  localparam int CW = $clog2(DELAY_FRAMES);

  logic                  rxMeta;
  logic                  rxS;
  rxState_t              state;
  rxState_t              stateNext;
  logic [CW-1:0]         bitCnt;
  logic [2:0]            bitIdx;
  logic [FRAME_BITS-1:0] shiftReg;
  logic                  halfDone;
  logic                  bitDone;
  logic                  cntClear;
  logic                  sampleBit;
  logic                  push;
  logic                  frameErrSet;
  logic                  pop;
  logic                  fifoFull;
  logic                  fifoEmpty;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= uartRx;
      rxS    <= rxMeta;
    end
  end

  assign halfDone = (bitCnt == CW'(DELAY_FRAMES / 2 - 1));
  assign bitDone  = (bitCnt == CW'(DELAY_FRAMES - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (!rxS) stateNext = START;
      START:     if (halfDone) stateNext = rxS ? IDLE : DATA;
      DATA:      if (bitDone && bitIdx == 3'd7) stateNext = STOP;
      STOP:      if (bitDone) stateNext = rxS ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxS) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    cntClear    = 1'b0;
    sampleBit   = 1'b0;
    push        = 1'b0;
    frameErrSet = 1'b0;
    case (state)
      IDLE:      cntClear = 1'b1;
      START:     cntClear = halfDone;
      DATA: begin
        cntClear  = bitDone;
        sampleBit = bitDone;
      end
      STOP: begin
        cntClear    = bitDone;
        push        = bitDone && rxS;
        frameErrSet = bitDone && !rxS;
      end
      default:   cntClear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bitCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
    end else begin
      bitCnt <= cntClear ? '0 : bitCnt + 1'b1;
      if (state != DATA) begin
        bitIdx <= '0;
      end else if (sampleBit) begin
        shiftReg[bitIdx] <= rxS;
        bitIdx           <= bitIdx + 1'b1;
      end
    end
  end

  assign pop = rxReady && rxValid;

  // A set event in the same cycle as errClear keeps the flag set.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frameError <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frameError <= frameErrSet || (frameError && !errClear);
      overflow   <= (push && fifoFull && !pop) || (overflow && !errClear);
    end
  end

  rx_fifo #(
    .WIDTH(FRAME_BITS),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .rstN    (rstN),
    .push    (push),
    .pushData(shiftReg),
    .pop     (pop),
    .popData (rxData),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  assign rxValid = !fifoEmpty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 234 cycles/bit with a 4-entry FIFO.
module tb_uart_rx;

  localparam int D = 234;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       uartRx = 1'b1;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady = 1'b0;
  logic       frameError;
  logic       overflow;
  logic       errClear = 1'b0;

  int nCmp = 0;
  int nBad = 0;
  int measLat = 2226;

  uart_rx #(.DELAY_FRAMES(D), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .uartRx    (uartRx),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .rxReady   (rxReady),
    .frameError(frameError),
    .overflow  (overflow),
    .errClear  (errClear)
  );

  always #5 clk = ~clk;

  // Line falls just after the first posedge; each bit lasts D cycles.
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      uartRx = frame[i];
      repeat (D) @(posedge clk);
      #1;
    end
  endtask

  task automatic doPop();
    @(negedge clk) rxReady = 1'b1;
    @(posedge clk); #1;
    rxReady = 1'b0;
  endtask

  task automatic pulseClear();
    @(negedge clk) errClear = 1'b1;
    @(posedge clk); #1;
    errClear = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL reset_rxValid: got %b want 0", rxValid); end
    nCmp++; if (rxData !== 8'h00) begin nBad++; $display("FAIL reset_rxData: got %h want 00", rxData); end
    nCmp++; if (frameError !== 1'b0) begin nBad++; $display("FAIL reset_frameError: got %b want 0", frameError); end
    nCmp++; if (overflow !== 1'b0) begin nBad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rstN = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n;
    n = 0;
    fork
      sendByte(8'h55, 1'b1);
      begin
        @(posedge clk);
        for (n = 1; n < 2400; n++) begin
          @(posedge clk); #2;
          if (rxValid) break;
        end
      end
    join
    measLat = rxValid ? n : 2226;
    nCmp++; if (n < 2225 || n > 2227) begin nBad++; $display("FAIL basic_latency: got %0d want 2226+-1", n); end
    nCmp++; if (rxData !== 8'h55) begin nBad++; $display("FAIL basic_data: got %h want 55", rxData); end
    doPop();
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL basic_pop_empty: got %b want 0", rxValid); end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1;
    uartRx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    uartRx = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL glitch_no_byte: got %b want 0", rxValid); end
    nCmp++; if (frameError !== 1'b0) begin nBad++; $display("FAIL glitch_frameError: got %b want 0", frameError); end
    nCmp++; if (overflow !== 1'b0) begin nBad++; $display("FAIL glitch_overflow: got %b want 0", overflow); end
    sendByte(8'h3C, 1'b1);
    nCmp++; if (rxValid !== 1'b1) begin nBad++; $display("FAIL glitch_next_valid: got %b want 1", rxValid); end
    nCmp++; if (rxData !== 8'h3C) begin nBad++; $display("FAIL glitch_next_data: got %h want 3c", rxData); end
    doPop();
  endtask

  task automatic test_frame_error();
    sendByte(8'hA5, 1'b0);
    repeat (3000) @(posedge clk);
    #1;
    nCmp++; if (frameError !== 1'b1) begin nBad++; $display("FAIL ferr_set: got %b want 1", frameError); end
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL ferr_no_byte: got %b want 0", rxValid); end
    uartRx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL ferr_break_no_byte: got %b want 0", rxValid); end
    nCmp++; if (frameError !== 1'b1) begin nBad++; $display("FAIL ferr_sticky: got %b want 1", frameError); end
    pulseClear();
    nCmp++; if (frameError !== 1'b0) begin nBad++; $display("FAIL ferr_clear: got %b want 0", frameError); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    rxReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      sendByte(b, 1'b1);
      if (i == 4) begin
        nCmp++; if (overflow !== 1'b0) begin nBad++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
      end
    end
    nCmp++; if (overflow !== 1'b1) begin nBad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      nCmp++; if (rxValid !== 1'b1) begin nBad++; $display("FAIL ovf_valid_%0d: got %b want 1", i, rxValid); end
      nCmp++; if (rxData !== b) begin nBad++; $display("FAIL ovf_data_%0d: got %h want %h", i, rxData, b); end
      doPop();
    end
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL ovf_drained: got %b want 0", rxValid); end
    pulseClear();
    nCmp++; if (overflow !== 1'b0) begin nBad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp [4];
    exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'h99;
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    sendByte(8'h33, 1'b1);
    sendByte(8'h44, 1'b1);
    fork
      sendByte(8'h99, 1'b1);
      begin
        @(posedge clk);
        repeat (measLat - 1) @(posedge clk);
        #1 rxReady = 1'b1;
        @(posedge clk); #1;
        rxReady = 1'b0;
      end
    join
    nCmp++; if (overflow !== 1'b0) begin nBad++; $display("FAIL fullpop_no_overflow: got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      nCmp++; if (rxData !== exp[i] || rxValid !== 1'b1) begin
        nBad++; $display("FAIL fullpop_entry_%0d: got %h (valid %b) want %h", i, rxData, rxValid, exp[i]);
      end
      doPop();
    end
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL fullpop_drained: got %b want 0", rxValid); end
  endtask

  task automatic test_reset_midframe();
    sendByte(8'h00, 1'b0);
    uartRx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    sendByte(8'h77, 1'b1);
    nCmp++; if (frameError !== 1'b1 || rxData !== 8'h77) begin
      nBad++; $display("FAIL rst_precond: got ferr %b data %h want 1 77", frameError, rxData);
    end
    fork
      sendByte(8'hF8, 1'b1);
      begin
        repeat (4 * D + D / 2) @(posedge clk);
        #1 rstN = 1'b0;
        #2;
        nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL rst_mid_rxValid: got %b want 0", rxValid); end
        nCmp++; if (rxData !== 8'h00) begin nBad++; $display("FAIL rst_mid_rxData: got %h want 00", rxData); end
        nCmp++; if (frameError !== 1'b0) begin nBad++; $display("FAIL rst_mid_frameError: got %b want 0", frameError); end
        @(posedge clk); #1;
        rstN = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL rst_partial_dropped: got %b want 0", rxValid); end
    sendByte(8'hC3, 1'b1);
    nCmp++; if (rxValid !== 1'b1 || rxData !== 8'hC3) begin
      nBad++; $display("FAIL rst_resume: got %h (valid %b) want c3", rxData, rxValid);
    end
    doPop();
    nCmp++; if (rxValid !== 1'b0) begin nBad++; $display("FAIL rst_resume_drained: got %b want 0", rxValid); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", nCmp);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overflow();
    test_full_pop_push();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
